rom_port_arbiter: RTL and testbench

Sequences the single toggle-handshake SDRAM port shared by ROM download, main-CPU ROM fetch and sound-CPU ROM fetch.
- Converts data_io byte writes into lane-masked word writes.
- Serves CPU and sound reads from one-word caches, arbitrating misses round-robin.
- Asserts rom_loaded when a download completes.

It sits between data_io, the game core ROM ports and the sdram controller, in the clk_sys domain.

---
 rtl/rom_arb_pkg.sv | 19 +
 rtl/rom_port_arbiter_if.sv | 24 ++
 rtl/rom_port_cache.sv | 41 ++++
 rtl/rom_port_arbiter.sv | 243 ++++++++++++++++++++++++
 tb/tb_rom_port_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rom_arb_pkg.sv
// Shared types and defaults for the ROM port arbiter: FSM states, requester ids,
// and the default sound ROM word offset.
package rom_arb_pkg;

   typedef enum logic {
      IDLE,
      WAIT
   } state_t;

   typedef enum logic [1:0] {
      REQ_DL,
      REQ_CPU,
      REQ_SND
   } req_t;

   localparam int          SDRAM_AW     = 23;
   localparam logic [22:0] SND_BASE_DEF = 23'h4000;

endpackage

// File: rtl/rom_port_arbiter_if.sv
// Toggle-handshake SDRAM port. A transaction starts when sdram_req toggles and is
// complete once sdram_ack equals sdram_req; a/ds/we/d are held stable meanwhile.
interface rom_port_arbiter_if;
   import rom_arb_pkg::*;

   logic                sdram_req;
   logic                sdram_ack;
   logic [SDRAM_AW-1:0] sdram_a;
   logic [1:0]          sdram_ds;
   logic                sdram_we;
   logic [15:0]         sdram_d;
   logic [15:0]         sdram_q;

   modport master (
      output sdram_req, sdram_a, sdram_ds, sdram_we, sdram_d,
      input  sdram_ack, sdram_q
   );

   modport slave (
      input  sdram_req, sdram_a, sdram_ds, sdram_we, sdram_d,
      output sdram_ack, sdram_q
   );

endinterface

// File: rtl/rom_port_cache.sv
// One-word read cache: tag/word/valid register, miss compare and byte select.
// Invalidate has priority over a fill arriving in the same cycle.
module rom_port_cache
   import rom_arb_pkg::*;
(
   input  logic                clk_sys,
   input  logic                reset_n,
   input  logic                i_inval,
   input  logic                i_fill,
   input  logic [SDRAM_AW-1:0] i_fill_tag,
   input  logic [15:0]         i_fill_word,
   input  logic [SDRAM_AW-1:0] i_req_tag,
   input  logic                i_byte_sel,
   output logic                o_miss,
   output logic                o_hit,
   output logic [7:0]          o_q
);

   logic [SDRAM_AW-1:0] r_tag;
   logic [15:0]         r_word;
   logic                r_valid;

   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         r_tag   <= '0;
         r_word  <= 16'hFFFF;
         r_valid <= 1'b0;
      end else if (i_inval) begin
         r_valid <= 1'b0;
      end else if (i_fill) begin
         r_tag   <= i_fill_tag;
         r_word  <= i_fill_word;
         r_valid <= 1'b1;
      end
   end

   assign o_hit  = r_valid && (r_tag == i_req_tag);
   assign o_miss = !o_hit;
   assign o_q    = i_byte_sel ? r_word[15:8] : r_word[7:0];

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares one toggle-handshake SDRAM port between ROM download, CPU and sound fetch.
// Define SND_PORT_EN to build the sound requester; otherwise snd_q = 8'hFF, snd_valid = 0.
module rom_port_arbiter
   import rom_arb_pkg::*;
#(
   parameter logic [22:0] SND_BASE = SND_BASE_DEF,
   parameter int          CPU_AW   = 15,
   parameter int          SND_AW   = 13
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic              ioctl_downl,
   input  logic              ioctl_wr,
   input  logic [24:0]       ioctl_addr,
   input  logic [7:0]        ioctl_dout,
   input  logic [CPU_AW-1:0] cpu_addr,
   output logic [7:0]        cpu_q,
   output logic              cpu_valid,
   input  logic [SND_AW-1:0] snd_addr,
   input  logic              snd_vma,
   output logic [7:0]        snd_q,
   output logic              snd_valid,
   output logic              rom_loaded,
   output logic              dl_overrun,
   output state_t            dbg_state,
   rom_port_arbiter_if.master sdram
);

   state_t              r_state;
   req_t                r_owner;
   req_t                r_rr;
   logic                r_req;
   logic                r_we;
   logic [SDRAM_AW-1:0] r_a;
   logic [1:0]          r_ds;
   logic [15:0]         r_d;
   logic                r_wr_d;
   logic                r_downl_d;
   logic                r_rom_loaded;
   logic                r_overrun;
   logic                r_dl_pend;
   logic [SDRAM_AW-1:0] r_dl_a;
   logic [1:0]          r_dl_ds;
   logic [15:0]         r_dl_d;

   logic                w_dl_rise;
   logic                w_done;
   logic                w_cpu_miss;
   logic                w_cpu_hit;
   logic                w_cpu_need;
   logic                w_snd_miss;
   logic                w_snd_need;
   logic [SDRAM_AW-1:0] w_cpu_tag;
   logic [SDRAM_AW-1:0] w_snd_tag;
   logic                w_gnt_any;
   req_t                w_gnt;
   logic [SDRAM_AW-1:0] w_gnt_a;
   logic [1:0]          w_gnt_ds;
   logic                w_gnt_we;
   logic [15:0]         w_gnt_d;

   assign w_dl_rise = ioctl_wr && !r_wr_d;
   assign w_done    = (r_state == WAIT) && (sdram.sdram_ack == r_req);
   assign w_cpu_tag = SDRAM_AW'(cpu_addr[CPU_AW-1:1]);

   rom_port_cache u_cpu_cache (
      .clk_sys     (clk_sys),
      .reset_n     (reset_n),
      .i_inval     (ioctl_downl),
      .i_fill      (w_done && (r_owner == REQ_CPU) && !ioctl_downl),
      .i_fill_tag  (r_a),
      .i_fill_word (sdram.sdram_q),
      .i_req_tag   (w_cpu_tag),
      .i_byte_sel  (cpu_addr[0]),
      .o_miss      (w_cpu_miss),
      .o_hit       (w_cpu_hit),
      .o_q         (cpu_q)
   );

   assign cpu_valid  = w_cpu_hit && !ioctl_downl;
   assign w_cpu_need = w_cpu_miss && !ioctl_downl;

`ifdef SND_PORT_EN
   // snd_vma comes from clk_aud; the address is captured only once vma is synchronized
   logic              r_vma_s1;
   logic              r_vma_s2;
   logic [SND_AW-1:0] r_snd_addr;
   logic              w_snd_hit;

   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         r_vma_s1   <= 1'b0;
         r_vma_s2   <= 1'b0;
         r_snd_addr <= '0;
      end else begin
         r_vma_s1 <= snd_vma;
         r_vma_s2 <= r_vma_s1;
         if (r_vma_s2) r_snd_addr <= snd_addr;
      end
   end

   assign w_snd_tag = SND_BASE + SDRAM_AW'(r_snd_addr[SND_AW-1:1]);

   rom_port_cache u_snd_cache (
      .clk_sys     (clk_sys),
      .reset_n     (reset_n),
      .i_inval     (ioctl_downl),
      .i_fill      (w_done && (r_owner == REQ_SND) && !ioctl_downl),
      .i_fill_tag  (r_a),
      .i_fill_word (sdram.sdram_q),
      .i_req_tag   (w_snd_tag),
      .i_byte_sel  (r_snd_addr[0]),
      .o_miss      (w_snd_miss),
      .o_hit       (w_snd_hit),
      .o_q         (snd_q)
   );

   assign snd_valid  = w_snd_hit && !ioctl_downl;
   assign w_snd_need = w_snd_miss && !ioctl_downl;

   logic w_unused_top;
   assign w_unused_top = ioctl_addr[24];
`else
   logic w_unused_snd;
   assign w_unused_snd = ^{snd_vma, snd_addr, ioctl_addr[24], SND_BASE};
   assign w_snd_tag    = '0;
   assign w_snd_miss   = 1'b0;
   assign w_snd_need   = 1'b0;
   assign snd_q        = 8'hFF;
   assign snd_valid    = 1'b0;
`endif

   // Download first; on a two-way read miss r_rr names the requester not served last
   always_comb begin
      w_gnt_any = 1'b0;
      w_gnt     = REQ_DL;
      if (r_dl_pend || w_dl_rise) begin
         w_gnt_any = 1'b1;
         w_gnt     = REQ_DL;
      end else if (w_cpu_need && w_snd_need) begin
         w_gnt_any = 1'b1;
         w_gnt     = r_rr;
      end else if (w_cpu_need) begin
         w_gnt_any = 1'b1;
         w_gnt     = REQ_CPU;
      end else if (w_snd_need) begin
         w_gnt_any = 1'b1;
         w_gnt     = REQ_SND;
      end
   end

   always_comb begin
      w_gnt_a  = '0;
      w_gnt_ds = 2'b11;
      w_gnt_we = 1'b0;
      w_gnt_d  = '0;
      case (w_gnt)
         REQ_DL: begin
            w_gnt_we = 1'b1;
            if (r_dl_pend) begin
               w_gnt_a  = r_dl_a;
               w_gnt_ds = r_dl_ds;
               w_gnt_d  = r_dl_d;
            end else begin
               w_gnt_a  = ioctl_addr[23:1];
               w_gnt_ds = {ioctl_addr[0], !ioctl_addr[0]};
               w_gnt_d  = {ioctl_dout, ioctl_dout};
            end
         end
         REQ_CPU: w_gnt_a = w_cpu_tag;
         REQ_SND: w_gnt_a = w_snd_tag;
         default: w_gnt_a = '0;
      endcase
   end

   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         r_state      <= IDLE;
         r_owner      <= REQ_DL;
         r_rr         <= REQ_CPU;
         r_req        <= 1'b0;
         r_we         <= 1'b0;
         r_a          <= '0;
         r_ds         <= '0;
         r_d          <= '0;
         r_wr_d       <= 1'b0;
         r_downl_d    <= 1'b0;
         r_rom_loaded <= 1'b0;
         r_overrun    <= 1'b0;
         r_dl_pend    <= 1'b0;
         r_dl_a       <= '0;
         r_dl_ds      <= '0;
         r_dl_d       <= '0;
      end else begin
         r_wr_d    <= ioctl_wr;
         r_downl_d <= ioctl_downl;
         if (r_downl_d && !ioctl_downl) r_rom_loaded <= 1'b1;

         // An idle FSM issues a fresh byte directly; a busy one parks it in the buffer
         if ((r_state == IDLE) && r_dl_pend) r_dl_pend <= 1'b0;
         if (w_dl_rise) begin
            if (r_dl_pend) begin
               r_overrun <= 1'b1;
            end else if (r_state != IDLE) begin
               r_dl_pend <= 1'b1;
               r_dl_a    <= ioctl_addr[23:1];
               r_dl_ds   <= {ioctl_addr[0], !ioctl_addr[0]};
               r_dl_d    <= {ioctl_dout, ioctl_dout};
            end
         end

         case (r_state)
            IDLE: begin
               if (w_gnt_any) begin
                  r_a     <= w_gnt_a;
                  r_ds    <= w_gnt_ds;
                  r_we    <= w_gnt_we;
                  r_d     <= w_gnt_d;
                  r_req   <= !r_req;
                  r_owner <= w_gnt;
                  if (w_gnt == REQ_CPU) r_rr <= REQ_SND;
                  else if (w_gnt == REQ_SND) r_rr <= REQ_CPU;
                  r_state <= WAIT;
               end
            end
            WAIT: begin
               if (w_done) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign sdram.sdram_req = r_req;
   assign sdram.sdram_a   = r_a;
   assign sdram.sdram_ds  = r_ds;
   assign sdram.sdram_we  = r_we;
   assign sdram.sdram_d   = r_d;
   assign rom_loaded      = r_rom_loaded;
   assign dl_overrun      = r_overrun;
   assign dbg_state       = r_state;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter with a toggle-ack SDRAM model of adjustable latency.
// Sound round-robin steps run when SND_PORT_EN is defined; otherwise the disabled port is checked.
module tb_rom_port_arbiter;
   import rom_arb_pkg::*;

   logic        clk_sys     = 1'b0;
   logic        reset_n     = 1'b0;
   logic        ioctl_downl = 1'b1;
   logic        ioctl_wr    = 1'b0;
   logic [24:0] ioctl_addr  = '0;
   logic [7:0]  ioctl_dout  = '0;
   logic [14:0] cpu_addr    = '0;
   logic [12:0] snd_addr    = '0;
   logic        snd_vma     = 1'b0;
   logic [7:0]  cpu_q;
   logic        cpu_valid;
   logic [7:0]  snd_q;
   logic        snd_valid;
   logic        rom_loaded;
   logic        dl_overrun;
   state_t      dbg_state;

   rom_port_arbiter_if sd ();

   rom_port_arbiter #(
      .SND_BASE (23'h4000),
      .CPU_AW   (15),
      .SND_AW   (13)
   ) dut (
      .clk_sys     (clk_sys),
      .reset_n     (reset_n),
      .ioctl_downl (ioctl_downl),
      .ioctl_wr    (ioctl_wr),
      .ioctl_addr  (ioctl_addr),
      .ioctl_dout  (ioctl_dout),
      .cpu_addr    (cpu_addr),
      .cpu_q       (cpu_q),
      .cpu_valid   (cpu_valid),
      .snd_addr    (snd_addr),
      .snd_vma     (snd_vma),
      .snd_q       (snd_q),
      .snd_valid   (snd_valid),
      .rom_loaded  (rom_loaded),
      .dl_overrun  (dl_overrun),
      .dbg_state   (dbg_state),
      .sdram       (sd)
   );

   // clock
   always #5 clk_sys = ~clk_sys;

   // SDRAM model: word memory initialised to addr ^ 16'hA55A, ack after ack_delay edges
   logic [15:0] mem [0:65535];
   int          ack_delay = 2;
   int          cnt;
   logic        busy;
   logic [22:0] log_a  [$];
   logic [1:0]  log_ds [$];
   logic        log_we [$];
   logic [15:0] log_d  [$];

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 16'(i) ^ 16'hA55A;
   end

   always @(posedge clk_sys) begin
      if (!reset_n) begin
         sd.sdram_ack <= 1'b0;
         sd.sdram_q   <= 16'h0000;
         cnt          <= 0;
         busy         <= 1'b0;
      end else if (sd.sdram_req != sd.sdram_ack) begin
         if (!busy) begin
            busy <= 1'b1;
            log_a.push_back(sd.sdram_a);
            log_ds.push_back(sd.sdram_ds);
            log_we.push_back(sd.sdram_we);
            log_d.push_back(sd.sdram_d);
            if (sd.sdram_we) begin
               if (sd.sdram_ds[0]) mem[sd.sdram_a[15:0]][7:0]  <= sd.sdram_d[7:0];
               if (sd.sdram_ds[1]) mem[sd.sdram_a[15:0]][15:8] <= sd.sdram_d[15:8];
            end
         end
         if (cnt >= ack_delay - 1) begin
            sd.sdram_ack <= sd.sdram_req;
            sd.sdram_q   <= mem[sd.sdram_a[15:0]];
            cnt          <= 0;
            busy         <= 1'b0;
         end else begin
            cnt <= cnt + 1;
         end
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk_sys);
   endtask

   task automatic pulse_wr(input logic [24:0] addr, input logic [7:0] data);
      ioctl_addr = addr;
      ioctl_dout = data;
      ioctl_wr   = 1'b1;
      tick(1);
      ioctl_wr   = 1'b0;
      tick(1);
   endtask

   task automatic wait_txns(input int target, input string tag);
      int n;
      n = 0;
      while (log_a.size() < target && n < 200) begin
         tick(1);
         n++;
      end
      check(tag, 32'(log_a.size()), 32'(target));
   endtask

   task automatic wait_cpu_valid(input string tag);
      int n;
      n = 0;
      while (!cpu_valid && n < 200) begin
         tick(1);
         n++;
      end
      check(tag, 32'(cpu_valid), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int n;

      // reset state
      tick(2);
      check("rst_req",       32'(sd.sdram_req), 32'd0);
      check("rst_we",        32'(sd.sdram_we),  32'd0);
      check("rst_a",         32'(sd.sdram_a),   32'd0);
      check("rst_ds",        32'(sd.sdram_ds),  32'd0);
      check("rst_d",         32'(sd.sdram_d),   32'd0);
      check("rst_cpu_q",     32'(cpu_q),        32'hFF);
      check("rst_cpu_valid", 32'(cpu_valid),    32'd0);
      check("rst_snd_q",     32'(snd_q),        32'hFF);
      check("rst_snd_valid", 32'(snd_valid),    32'd0);
      check("rst_loaded",    32'(rom_loaded),   32'd0);
      check("rst_overrun",   32'(dl_overrun),   32'd0);
      check("rst_state",     32'(dbg_state),    32'(IDLE));
      reset_n = 1'b1;
      tick(1);

      // download 0x12 @0 and 0x34 @1: req toggles on the edge that sees ioctl_wr rise
      ack_delay  = 2;
      ioctl_addr = 25'd0;
      ioctl_dout = 8'h12;
      ioctl_wr   = 1'b1;
      tick(1);
      check("dl0_req_toggle", 32'(sd.sdram_req), 32'd1);
      ioctl_wr = 1'b0;
      tick(6);
      ioctl_addr = 25'd1;
      ioctl_dout = 8'h34;
      ioctl_wr   = 1'b1;
      tick(1);
      check("dl1_req_toggle", 32'(sd.sdram_req), 32'd0);
      ioctl_wr = 1'b0;
      tick(6);
      check("dl_count", 32'(log_a.size()), 32'd2);
      check("dl0_a",    32'(log_a[0]),  32'd0);
      check("dl0_ds",   32'(log_ds[0]), 32'b01);
      check("dl0_d",    32'(log_d[0]),  32'h1212);
      check("dl0_we",   32'(log_we[0]), 32'd1);
      check("dl1_a",    32'(log_a[1]),  32'd0);
      check("dl1_ds",   32'(log_ds[1]), 32'b10);
      check("dl1_d",    32'(log_d[1]),  32'h3434);
      check("dl_cpu_valid_blocked", 32'(cpu_valid), 32'd0);

      // CPU miss at byte 1 with a 4-cycle ack: grant edge, 4 edges to ack, 1 fill edge
      ack_delay   = 4;
      ioctl_downl = 1'b0;
      cpu_addr    = 15'd1;
      n = 0;
      do begin
         tick(1);
         n++;
      end while (!cpu_valid && n < 40);
      check("cpu_miss_latency", 32'(n),           32'd6);
      check("rom_loaded_set",   32'(rom_loaded),  32'd1);
      check("cpu_q_byte1",      32'(cpu_q),       32'h34);
      check("cpu_rd_count",     32'(log_a.size()), 32'd3);
      check("cpu_rd_a",         32'(log_a[2]),    32'd0);
      check("cpu_rd_we",        32'(log_we[2]),   32'd0);

      // same word, other byte: combinational hit, no new request
      cpu_addr = 15'd0;
      #1;
      check("cpu_hit_valid", 32'(cpu_valid), 32'd1);
      check("cpu_hit_q",     32'(cpu_q),     32'h12);
      tick(3);
      check("cpu_hit_no_req", 32'(log_a.size()), 32'd3);

      // overrun: first byte issued, second parked, third dropped
      ack_delay   = 20;
      ioctl_downl = 1'b1;
      tick(1);
      base = log_a.size();
      pulse_wr(25'h10, 8'hAA);
      pulse_wr(25'h11, 8'hBB);
      pulse_wr(25'h12, 8'hCC);
      check("overrun_flag", 32'(dl_overrun), 32'd1);
      tick(60);
      check("overrun_count", 32'(log_a.size()),   32'(base + 2));
      check("overrun_a0",    32'(log_a[base]),    32'h8);
      check("overrun_ds0",   32'(log_ds[base]),   32'b01);
      check("overrun_a1",    32'(log_a[base+1]),  32'h8);
      check("overrun_ds1",   32'(log_ds[base+1]), 32'b10);
      check("overrun_d1",    32'(log_d[base+1]),  32'hBBBB);

      // reset during a read WAIT abandons it; the fetch is reissued afterwards
      ack_delay   = 10;
      ioctl_downl = 1'b0;
      cpu_addr    = 15'd2;
      tick(3);
      check("rstw_state_wait", 32'(dbg_state), 32'(WAIT));
      reset_n = 1'b0;
      tick(1);
      check("rstw_req",       32'(sd.sdram_req), 32'd0);
      check("rstw_cpu_valid", 32'(cpu_valid),    32'd0);
      check("rstw_cpu_q",     32'(cpu_q),        32'hFF);
      check("rstw_loaded",    32'(rom_loaded),   32'd0);
      check("rstw_overrun",   32'(dl_overrun),   32'd0);
      base      = log_a.size();
      reset_n   = 1'b1;
      ack_delay = 2;
      wait_cpu_valid("rstw_refetch_valid");
      check("rstw_refetch_count", 32'(log_a.size()),   32'(base + 1));
      check("rstw_refetch_a",     32'(log_a[base]),    32'd1);
      check("rstw_refetch_q",     32'(cpu_q),          32'h5B);

`ifdef SND_PORT_EN
      // simultaneous misses right after reset: CPU favoured first
      reset_n     = 1'b0;
      ioctl_downl = 1'b1;
      tick(2);
      reset_n  = 1'b1;
      cpu_addr = 15'd2;
      snd_addr = 13'd6;
      snd_vma  = 1'b1;
      tick(5);
      base        = log_a.size();
      ioctl_downl = 1'b0;
      wait_txns(base + 2, "rr1_count");
      check("rr1_first_cpu",  32'(log_a[base]),   32'h1);
      check("rr1_second_snd", 32'(log_a[base+1]), 32'h4003);
      tick(10);
      check("rr1_cpu_valid", 32'(cpu_valid), 32'd1);
      check("rr1_cpu_q",     32'(cpu_q),     32'h5B);
      check("rr1_snd_valid", 32'(snd_valid), 32'd1);
      check("rr1_snd_q",     32'(snd_q),     32'h59);

      // CPU-only miss leaves sound favoured for the next tie
      cpu_addr = 15'd4;
      wait_txns(base + 3, "rr2_count");
      check("rr2_cpu_a", 32'(log_a[base+2]), 32'h2);
      tick(6);

      ioctl_downl = 1'b1;
      cpu_addr    = 15'd6;
      snd_addr    = 13'd9;
      tick(5);
      ioctl_downl = 1'b0;
      wait_txns(base + 5, "rr3_count");
      check("rr3_first_snd",  32'(log_a[base+3]), 32'h4004);
      check("rr3_second_cpu", 32'(log_a[base+4]), 32'h3);
      tick(10);
      check("rr3_snd_q", 32'(snd_q), 32'hE5);
      check("rr3_cpu_q", 32'(cpu_q), 32'h59);
`else
      // sound port absent: vma activity produces no requests
      base     = log_a.size();
      snd_addr = 13'd3;
      for (int i = 0; i < 4; i++) begin
         snd_vma = ~snd_vma;
         tick(3);
      end
      check("nosnd_no_req", 32'(log_a.size()), 32'(base));
      check("nosnd_q",      32'(snd_q),        32'hFF);
      check("nosnd_valid",  32'(snd_valid),    32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
